display_sched: RTL
==================

// Module: display_sched
// PURPOSE
// Shares the single 4-digit seven-segment display between NREQ counter banks. Each bank
// raises a request pulse when its value changes. A round-robin scheduler grants the display
// to one bank for a fixed dwell, then inserts a short blank gap before the next grant.
// The block sits between the counter datapaths and sevenseg_display, and is paced by ce1ms.
// PARAMETERS
// NREQ      4    number of requesting banks (2..8)
// HOLD_MS   1000 ms a granted bank stays on the display
// BLANK_MS  100  ms of blank display between two grants (0 = no gap)
// PORTS
// clk       in   1          system clock
// rst       in   1          asynchronous, active-low reset
// ce1ms     in   1          1-cycle strobe every 1 ms (from gennms_1s)
// req       in   NREQ       per-bank 1-cycle pulse: "my value changed, show me"
// auto_rot  in   1          1 = rotate through all banks when nothing is pending
// dat_in    in   16*NREQ    bank k value at dat_in[16k+15:16k]
// dat       out  16         value driven to sevenseg_display
// blank     out  1          1 = display must be dark (gap or idle)
// grant     out  NREQ       one-hot owner of the display, 0 when blank
// owner     out  $clog2(NREQ) index of the last/current owner
// pending   out  NREQ       latched, not-yet-served requests
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, dat=0, blank=1, grant=0, owner=0, pending=0, timer=0.
// - pending[k] is set on req[k] and cleared when bank k is granted. If set and clear occur
//   in the same cycle, set wins, so pending stays 1.
// - FSM states: IDLE, SHOW, GAP.
//   IDLE: if pending!=0, grant the first set bit searching upward from owner+1 (mod NREQ) -> SHOW.
//         Else, if auto_rot=1, grant (owner+1) mod NREQ -> SHOW.
//         Else stay in IDLE with blank=1.
//   SHOW: timer counts ce1ms strobes. At timer==HOLD_MS-1 together with ce1ms:
//         go to GAP if BLANK_MS>0, otherwise re-arbitrate directly as in IDLE.
//   GAP:  blank=1, grant=0. At timer==BLANK_MS-1 together with ce1ms: re-arbitrate as in IDLE.
// - A req from the current owner during SHOW restarts the timer (extends the dwell) and does
//   NOT set pending.
// - dat is a registered copy of the owner's live slice, updated every cycle in SHOW
//   (1-cycle latency from dat_in). dat holds its last value in GAP/IDLE; blank masks it.
// - The grant decision is made and registered in one cycle. grant, owner and blank change
//   on the same edge.
// - The timer clears on every state entry. The timer is wide enough for max(HOLD_MS, BLANK_MS).
// - Wrap-around: the round-robin search wraps from NREQ-1 to 0. owner==NREQ-1 with only
//   pending[0] set grants bank 0.
// - When auto_rot drops to 0 mid-SHOW, the current dwell completes. The FSM then goes to IDLE
//   if nothing is pending.
// STRUCTURE
// - display_sched_pkg: state_t enum {IDLE, SHOW, GAP}; function clog2_min1; MS_TIMER_W constant.
// - Sub-module rr_arbiter #(N): inputs req_vec and last index; outputs one-hot gnt, gnt index
//   and any. It is purely combinational with a rotate-priority search.
// - Top: pending register, FSM, ms timer, output mux and register.
// TESTING
// 1 Reset mid-SHOW (rst low 3 cycles) -> blank=1, grant=0, pending=0, dat=0 immediately (async).
// 2 NREQ=4, HOLD_MS=3, BLANK_MS=1, owner=0; pulse req[2] and req[1] in the same cycle
//   -> grant=0010 for 3 ms, 1 ms blank, then grant=0100.
// 3 Owner=3, only req[0] pending -> wrap-around; the next grant is 0001 and owner=0.
// 4 During SHOW of bank 1, pulse req[1] at ms 2 -> dwell ends 3 ms after the pulse;
//   pending[1] stays 0.
// 5 auto_rot=1, no req, BLANK_MS=0 -> grant cycles 0001,0010,0100,1000,0001 every HOLD_MS;
//   blank never asserts.
// 6 Change bank 2's dat_in while bank 2 is shown -> dat follows 1 cycle later;
//   req[k] and the pending clear in the same cycle -> pending[k]=1.

Source files
------------

// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display scheduler: FSM encoding, millisecond timer width.
// HOLD_MS and BLANK_MS must both fit in MS_TIMER_W bits.
package display_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int MS_TIMER_W = 16;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_sched_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_vec searching upward from last+1, wrapping.
// Zero latency; no flow control, any=0 when req_vec is empty.
module rr_arbiter
  import display_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req_vec,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    // i runs 1..N so that the last owner is considered only after every other bank
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last) + i) % N);
      if (!any && req_vec[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/display_sched.sv
// Time-shares one 4-digit display between NREQ counter banks: round-robin grant, HOLD_MS dwell, BLANK_MS gap.
// Grant/owner/blank are registered (decision to output in one edge); dat trails dat_in by one cycle.
module display_sched
  import display_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MS  = 1000,
  parameter int BLANK_MS = 100,
  localparam int OW      = clog2_min1(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce1ms,
  input  logic [NREQ-1:0]    req,
  input  logic               auto_rot,
  input  logic [16*NREQ-1:0] dat_in,
  output logic [15:0]        dat,
  output logic               blank,
  output logic [NREQ-1:0]    grant,
  output logic [OW-1:0]      owner,
  output logic [NREQ-1:0]    pending
);

  localparam logic [MS_TIMER_W-1:0] HOLD_LAST  = MS_TIMER_W'(HOLD_MS - 1);
  localparam logic [MS_TIMER_W-1:0] BLANK_LAST = MS_TIMER_W'((BLANK_MS > 0) ? BLANK_MS - 1 : 0);

  state_t                 state_q, state_d;
  logic [MS_TIMER_W-1:0]  timer_q, timer_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        pending_q, pending_d;
  logic                   blank_q, blank_d;
  logic [15:0]            dat_q, dat_d;

  logic [15:0]            bank_dat [NREQ];
  logic [NREQ-1:0]        arb_gnt;
  logic [OW-1:0]          arb_idx;
  logic                   arb_any;
  logic [OW-1:0]          rot_idx;
  logic [NREQ-1:0]        clr_vec;
  logic                   do_arb;
  logic                   owner_req;

  for (genvar g = 0; g < NREQ; g++) begin : g_bank
    assign bank_dat[g] = dat_in[16*g +: 16];
  end

  rr_arbiter #(.N(NREQ), .W(OW)) u_arb (
    .req_vec (pending_q),
    .last    (owner_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign rot_idx = OW'((int'(owner_q) + 1) % NREQ);

  // grant_q is zero outside SHOW, so it masks exactly the current owner's own request
  assign owner_req = (state_q == SHOW) && |(req & grant_q);
  assign pending_d = (pending_q & ~clr_vec) | (req & ~grant_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    clr_vec = '0;
    do_arb  = 1'b0;
    unique case (state_q)
      IDLE: do_arb = 1'b1;
      SHOW: begin
        if (owner_req) begin
          timer_d = '0;
        end else if (ce1ms) begin
          if (timer_q == HOLD_LAST) begin
            if (BLANK_MS > 0) begin
              state_d = GAP;
              timer_d = '0;
            end else begin
              do_arb = 1'b1;
            end
          end else begin
            timer_d = timer_q + MS_TIMER_W'(1);
          end
        end
      end
      GAP: begin
        if (ce1ms) begin
          if (timer_q == BLANK_LAST) do_arb = 1'b1;
          else timer_d = timer_q + MS_TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_arb) begin
      timer_d = '0;
      if (arb_any) begin
        state_d = SHOW;
        owner_d = arb_idx;
        clr_vec = arb_gnt;
      end else if (auto_rot) begin
        state_d          = SHOW;
        owner_d          = rot_idx;
        clr_vec[rot_idx] = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    blank_d = 1'b1;
    dat_d   = dat_q;
    if (state_d == SHOW) begin
      grant_d[owner_d] = 1'b1;
      blank_d          = 1'b0;
      dat_d            = bank_dat[owner_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      pending_q <= '0;
      blank_q   <= 1'b1;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      blank_q   <= blank_d;
      dat_q     <= dat_d;
    end
  end

  assign dat     = dat_q;
  assign blank   = blank_q;
  assign grant   = grant_q;
  assign owner   = owner_q;
  assign pending = pending_q;

endmodule
